arena_painter: RTL and testbench

//  Parametrised full-screen arena renderer. Next-generation painter for the Bomberman playfield.
//  On a start pulse it walks the screen once in raster order and emits one pixel write per beat.

---
 rtl/arena_painter.sv | 260 ++++++++++++++++++++++++++
 tb/tb_arena_painter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/arena_painter.sv
// Full-screen arena renderer: walks the screen in raster order, one back-pressured pixel write per beat.
// Optional single-tile repaint is enabled with `define ARENA_TILE_REDRAW_EN.
module arena_painter #(
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480,
  parameter int unsigned BORDER   = 40,
  parameter int unsigned TILE     = 40,
  parameter int unsigned CW       = 8,
  parameter int unsigned XW       = 10,
  parameter int unsigned YW       = 9
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  input  logic            start,
  input  logic [3*CW-1:0] wall_rgb,
  input  logic [3*CW-1:0] floor_rgb,
`ifdef ARENA_TILE_REDRAW_EN
  input  logic            tile_start,
  input  logic [4:0]      tile_col,
  input  logic [4:0]      tile_row,
`endif
  input  logic            pix_ready,
  output logic            pix_valid,
  output logic [XW-1:0]   pix_x,
  output logic [YW-1:0]   pix_y,
  output logic [3*CW-1:0] pix_rgb,
  output logic            busy,
  output logic            done
);

  localparam int unsigned RW = 3 * CW;

  localparam logic [XW-1:0] X_LAST  = XW'(SCREEN_W - 1);
  localparam logic [XW-1:0] X_BL    = XW'(BORDER);
  localparam logic [XW-1:0] X_BR    = XW'(SCREEN_W - BORDER);
  localparam logic [XW-1:0] XPH_END = XW'(TILE - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(SCREEN_H - 1);
  localparam logic [YW-1:0] Y_BL    = YW'(BORDER);
  localparam logic [YW-1:0] Y_BR    = YW'(SCREEN_H - BORDER);
  localparam logic [YW-1:0] YPH_END = YW'(TILE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAINT,
    S_FLUSH
  } state_t;

  state_t         state_q;
  logic           valid_q;
  logic           busy_q;
  logic           done_q;
  logic [XW-1:0]  x_q;
  logic [YW-1:0]  y_q;
  logic [RW-1:0]  rgb_q;
  logic [RW-1:0]  wall_q;
  logic [RW-1:0]  floor_q;

  // Tile index / phase of the pixel currently presented on pix_x/pix_y
  logic [XW-1:0]  cx_q;
  logic [XW-1:0]  px_q;
  logic [YW-1:0]  cy_q;
  logic [YW-1:0]  py_q;

  // Region bounds for the current pass (full screen or one tile)
  logic [XW-1:0]  x_lo_q;
  logic [XW-1:0]  x_hi_q;
  logic [YW-1:0]  y_hi_q;
  logic [XW-1:0]  cx0_q;

  logic [XW-1:0]  x_d;
  logic [YW-1:0]  y_d;
  logic [XW-1:0]  cx_d;
  logic [XW-1:0]  px_d;
  logic [YW-1:0]  cy_d;
  logic [YW-1:0]  py_d;
  logic [RW-1:0]  rgb_d;
  logic           line_end;
  logic           last_pix;

  logic           launch;
  logic           l_empty;
  logic [XW-1:0]  l_x;
  logic [YW-1:0]  l_y;
  logic [XW-1:0]  l_xhi;
  logic [YW-1:0]  l_yhi;
  logic [XW-1:0]  l_cx;
  logic [YW-1:0]  l_cy;
  logic [RW-1:0]  l_rgb;

`ifdef ARENA_TILE_REDRAW_EN
  logic [31:0]    t_xoff;
  logic [31:0]    t_yoff;
`endif

  function automatic logic [RW-1:0] paint(
    input logic [XW-1:0] x,
    input logic [YW-1:0] y,
    input logic          col_odd,
    input logic          row_odd,
    input logic [RW-1:0] wall_c,
    input logic [RW-1:0] floor_c
  );
    logic border;
    border = (x < X_BL) || (x >= X_BR) || (y < Y_BL) || (y >= Y_BR);
    if (border || (col_odd && row_odd)) begin
      return wall_c;
    end
    return floor_c;
  endfunction

  // Counters only start advancing once the raster enters the interior,
  // so index/phase equal (coord-BORDER)/TILE and (coord-BORDER) mod TILE there.
  always_comb begin
    line_end = (x_q == x_hi_q);
    last_pix = line_end && (y_q == y_hi_q);
    x_d  = x_q;
    y_d  = y_q;
    cx_d = cx_q;
    px_d = px_q;
    cy_d = cy_q;
    py_d = py_q;
    if (line_end) begin
      x_d  = x_lo_q;
      cx_d = cx0_q;
      px_d = '0;
      y_d  = y_q + 1'b1;
      if (y_q < Y_BL) begin
        cy_d = '0;
        py_d = '0;
      end else if (py_q == YPH_END) begin
        cy_d = cy_q + 1'b1;
        py_d = '0;
      end else begin
        py_d = py_q + 1'b1;
      end
    end else begin
      x_d = x_q + 1'b1;
      if (x_q < X_BL) begin
        cx_d = '0;
        px_d = '0;
      end else if (px_q == XPH_END) begin
        cx_d = cx_q + 1'b1;
        px_d = '0;
      end else begin
        px_d = px_q + 1'b1;
      end
    end
    rgb_d = paint(x_d, y_d, cx_d[0], cy_d[0], wall_q, floor_q);
  end

  always_comb begin
    launch  = start;
    l_empty = 1'b0;
    l_x     = '0;
    l_y     = '0;
    l_xhi   = X_LAST;
    l_yhi   = Y_LAST;
    l_cx    = '0;
    l_cy    = '0;
`ifdef ARENA_TILE_REDRAW_EN
    t_xoff = 32'(tile_col) * TILE;
    t_yoff = 32'(tile_row) * TILE;
    if (!start && tile_start) begin
      launch  = 1'b1;
      l_empty = (t_xoff >= SCREEN_W - 2 * BORDER) || (t_yoff >= SCREEN_H - 2 * BORDER);
      l_x     = XW'(BORDER + t_xoff);
      l_y     = YW'(BORDER + t_yoff);
      l_xhi   = XW'(BORDER + t_xoff + TILE - 1);
      l_yhi   = YW'(BORDER + t_yoff + TILE - 1);
      l_cx    = XW'(tile_col);
      l_cy    = YW'(tile_row);
    end
`endif
    l_rgb = paint(l_x, l_y, l_cx[0], l_cy[0], wall_rgb, floor_rgb);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      rgb_q   <= '0;
      wall_q  <= '0;
      floor_q <= '0;
      cx_q    <= '0;
      px_q    <= '0;
      cy_q    <= '0;
      py_q    <= '0;
      x_lo_q  <= '0;
      x_hi_q  <= '0;
      y_hi_q  <= '0;
      cx0_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (launch) begin
            wall_q  <= wall_rgb;
            floor_q <= floor_rgb;
            x_q     <= l_x;
            y_q     <= l_y;
            rgb_q   <= l_rgb;
            cx_q    <= l_cx;
            px_q    <= '0;
            cy_q    <= l_cy;
            py_q    <= '0;
            x_lo_q  <= l_x;
            x_hi_q  <= l_xhi;
            y_hi_q  <= l_yhi;
            cx0_q   <= l_cx;
            valid_q <= !l_empty;
            busy_q  <= 1'b1;
            state_q <= S_PAINT;
          end
        end
        S_PAINT: begin
          if (!valid_q) begin
            // Empty region: nothing to emit, finish straight away
            done_q  <= 1'b1;
            state_q <= S_FLUSH;
          end else if (pix_ready) begin
            if (last_pix) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_FLUSH;
            end else begin
              x_q   <= x_d;
              y_q   <= y_d;
              cx_q  <= cx_d;
              px_q  <= px_d;
              cy_q  <= cy_d;
              py_q  <= py_d;
              rgb_q <= rgb_d;
            end
          end
        end
        S_FLUSH: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign pix_valid = valid_q;
  assign pix_x     = x_q;
  assign pix_y     = y_q;
  assign pix_rgb   = rgb_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_arena_painter.sv
// Self-checking bench for arena_painter on a 16x12 screen with 2-pixel border and 2-pixel tiles.
module tb_arena_painter;

  localparam int W = 16;
  localparam int H = 12;
  localparam int B = 2;
  localparam int T = 2;
  localparam logic [23:0] WALL = 24'h4D4F4C;
  localparam logic [23:0] FLR  = 24'h246803;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [23:0] wall_rgb = '0;
  logic [23:0] floor_rgb = '0;
  logic        pix_ready = 1'b0;
  logic        pix_valid;
  logic [4:0]  pix_x;
  logic [3:0]  pix_y;
  logic [23:0] pix_rgb;
  logic        busy;
  logic        done;
`ifdef ARENA_TILE_REDRAW_EN
  logic        tile_start = 1'b0;
  logic [4:0]  tile_col = '0;
  logic [4:0]  tile_row = '0;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic [23:0] cap_rgb [W*H];

  typedef struct {
    int          x;
    int          y;
    logic [23:0] rgb;
  } spot_t;
  spot_t spots [10];

  always #5 clk = ~clk;

  arena_painter #(
    .SCREEN_W(W), .SCREEN_H(H), .BORDER(B), .TILE(T), .CW(8), .XW(5), .YW(4)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .start    (start),
    .wall_rgb (wall_rgb),
    .floor_rgb(floor_rgb),
`ifdef ARENA_TILE_REDRAW_EN
    .tile_start(tile_start),
    .tile_col (tile_col),
    .tile_row (tile_row),
`endif
    .pix_ready(pix_ready),
    .pix_valid(pix_valid),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .pix_rgb  (pix_rgb),
    .busy     (busy),
    .done     (done)
  );

  // Colour straight from the arena rule using plain division
  function automatic logic [23:0] exp_rgb(input int x, input int y);
    if (x < B || x >= W - B || y < B || y >= H - B) return WALL;
    if ((((x - B) / T) % 2 == 1) && (((y - B) / T) % 2 == 1)) return WALL;
    return FLR;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_frame(input bit stall, input bit disturb, input bit abort);
    int beats;
    int cyc;
    bit held;
    logic [4:0]  hx;
    logic [3:0]  hy;
    logic [23:0] hrgb;
    beats = 0;
    cyc   = 0;
    held  = 1'b0;
    hx    = '0;
    hy    = '0;
    hrgb  = '0;
    @(negedge clk);
    wall_rgb  = WALL;
    floor_rgb = FLR;
    start     = 1'b1;
    pix_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("first_valid", 32'(pix_valid), 1);
    check("first_x", 32'(pix_x), 0);
    check("first_y", 32'(pix_y), 0);
    check("busy_run", 32'(busy), 1);
    while (beats < W*H && cyc < 4000) begin
      if (abort && beats == 100) break;
      if (held) begin
        check("stall_x", 32'(pix_x), 32'(hx));
        check("stall_y", 32'(pix_y), 32'(hy));
        check("stall_rgb", 32'(pix_rgb), 32'(hrgb));
      end
      if (done) check("done_early", 32'(done), 0);
      pix_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      held = 1'b0;
      if (pix_valid && pix_ready) begin
        check("beat_x", 32'(pix_x), 32'(beats % W));
        check("beat_y", 32'(pix_y), 32'(beats / W));
        check("beat_rgb", 32'(pix_rgb), 32'(exp_rgb(beats % W, beats / W)));
        cap_rgb[beats] = pix_rgb;
        beats++;
        if (disturb && beats == 50) begin
          start     = 1'b1;
          wall_rgb  = 24'hABCDEF;
          floor_rgb = 24'h010203;
        end
      end else if (pix_valid) begin
        held = 1'b1;
        hx   = pix_x;
        hy   = pix_y;
        hrgb = pix_rgb;
      end else begin
        check("valid_gap", 32'(pix_valid), 1);
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    if (abort) begin
      check("abort_reached", 32'(beats), 100);
      reset = 1'b1;
      #1;
      check("abort_valid", 32'(pix_valid), 0);
      check("abort_busy", 32'(busy), 0);
      check("abort_done", 32'(done), 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (4) begin
        @(negedge clk);
        check("post_abort_done", 32'(done), 0);
        check("post_abort_valid", 32'(pix_valid), 0);
      end
    end else begin
      check("beat_count", 32'(beats), 32'(W*H));
      check("done_pulse", 32'(done), 1);
      check("valid_after", 32'(pix_valid), 0);
      @(negedge clk);
      check("done_width", 32'(done), 0);
      check("busy_end", 32'(busy), 0);
    end
  endtask

  initial begin
    spots[0] = '{0, 0, WALL};
    spots[1] = '{2, 2, FLR};
    spots[2] = '{3, 3, FLR};
    spots[3] = '{4, 4, WALL};
    spots[4] = '{5, 5, WALL};
    spots[5] = '{6, 4, FLR};
    spots[6] = '{14, 5, WALL};
    spots[7] = '{15, 11, WALL};
    spots[8] = '{12, 7, FLR};
    spots[9] = '{11, 9, FLR};

    repeat (2) @(negedge clk);
    check("rst_valid", 32'(pix_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rgb", 32'(pix_rgb), 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);

    run_frame(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("spot_%0d_%0d", spots[i].x, spots[i].y),
            32'(cap_rgb[spots[i].y * W + spots[i].x]), 32'(spots[i].rgb));
    end

    run_frame(1'b1, 1'b0, 1'b0);
    run_frame(1'b0, 1'b1, 1'b0);
    run_frame(1'b0, 1'b0, 1'b1);
    run_frame(1'b1, 1'b0, 1'b0);

`ifdef ARENA_TILE_REDRAW_EN
    begin
      int tb_beats;
      int exp_x [4];
      int exp_y [4];
      exp_x = '{4, 5, 4, 5};
      exp_y = '{4, 4, 5, 5};
      tb_beats = 0;
      @(negedge clk);
      wall_rgb = WALL; floor_rgb = FLR;
      tile_col = 5'd1; tile_row = 5'd1; tile_start = 1'b1; pix_ready = 1'b1;
      @(negedge clk);
      tile_start = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
        if (pix_valid && tb_beats < 4) begin
          check("tile_x", 32'(pix_x), 32'(exp_x[tb_beats]));
          check("tile_y", 32'(pix_y), 32'(exp_y[tb_beats]));
          check("tile_rgb", 32'(pix_rgb), 32'(WALL));
          tb_beats++;
        end
        @(negedge clk);
      end
      check("tile_beats", 32'(tb_beats), 4);
      check("tile_done", 32'(done), 1);
      repeat (2) @(negedge clk);
      tile_col = 5'd6; tile_start = 1'b1;
      @(negedge clk);
      tile_start = 1'b0;
      check("oor_valid", 32'(pix_valid), 0);
      @(negedge clk);
      check("oor_done", 32'(done), 1);
      check("oor_valid2", 32'(pix_valid), 0);
      repeat (2) @(negedge clk);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
